// File: rtl/snake_body.sv
// -----------------------------------------------------------------------------
// snake_body
//   Snake state keeper feeding the apple placer. Holds the committed travel
//   direction, the head position and a shift buffer of body segments. Each
//   accepted step advances the head (growing the body when an apple was
//   eaten), then a sequential scan compares every live body segment with the
//   new head to detect self-collision.
//
// Configuration macro:
//   SNAKE_WRAP_EN  defined   -> head wraps at the playfield edges
//                  undefined -> moving past an edge is a wall hit (game over)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   step              one-cycle movement tick (honoured only in IDLE)
//   dir_valid/dir_req direction request (0 up, 1 right, 2 down, 3 left)
//   apple_eaten       level from the apple placer; rising edge queues growth
//   rd_idx            segment read index (0 = head)
//   x_snake, y_snake  head position
//   length            current length, zero-extended to 10 bits
//   rd_x, rd_y        registered segment at rd_idx
//   rd_valid          registered (rd_idx < length)
//   busy              high in any state other than IDLE
//   game_over         sticky collision / wall flag
// -----------------------------------------------------------------------------
module snake_body #(
   parameter int H_LOGIC_WIDTH = 5,
   parameter int V_LOGIC_WIDTH = 5,
   parameter int H_LOGIC_MAX   = 31,
   parameter int V_LOGIC_MAX   = 23,
   parameter int MAX_LEN       = 32,
   parameter int IDX_WIDTH     = 5,
   parameter int INIT_LEN      = 3,
   parameter int INIT_X        = 16,
   parameter int INIT_Y        = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     step,
   input  logic                     dir_valid,
   input  logic [1:0]               dir_req,
   input  logic                     apple_eaten,
   input  logic [IDX_WIDTH-1:0]     rd_idx,
   output logic [H_LOGIC_WIDTH-1:0] x_snake,
   output logic [V_LOGIC_WIDTH-1:0] y_snake,
   output logic [9:0]               length,
   output logic [H_LOGIC_WIDTH-1:0] rd_x,
   output logic [V_LOGIC_WIDTH-1:0] rd_y,
   output logic                     rd_valid,
   output logic                     busy,
   output logic                     game_over
);

   localparam int LW = IDX_WIDTH + 1;
   localparam logic [H_LOGIC_WIDTH-1:0] XMAX = H_LOGIC_WIDTH'(H_LOGIC_MAX);
   localparam logic [V_LOGIC_WIDTH-1:0] YMAX = V_LOGIC_WIDTH'(V_LOGIC_MAX);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
   localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [1:0] {IDLE, MOVE, CHECK, DEAD} state_t;

   state_t                                  state_q, state_d;
   logic [1:0]                              dir_q, dir_d;
   logic [1:0]                              pend_q, pend_d;
   logic                                    apple_prev_q, apple_prev_d;
   logic                                    grow_pend_q, grow_pend_d;
   logic                                    grow_now_q, grow_now_d;
   logic [LW-1:0]                           len_q, len_d;
   logic [IDX_WIDTH-1:0]                    k_q, k_d;
   logic                                    go_q, go_d;
   logic [MAX_LEN-1:0][H_LOGIC_WIDTH-1:0]   seg_x_q, seg_x_d;
   logic [MAX_LEN-1:0][V_LOGIC_WIDTH-1:0]   seg_y_q, seg_y_d;
   logic [H_LOGIC_WIDTH-1:0]                rd_x_q, rd_x_d;
   logic [V_LOGIC_WIDTH-1:0]                rd_y_q, rd_y_d;
   logic                                    rd_valid_q, rd_valid_d;

   logic [H_LOGIC_WIDTH-1:0] nx;
   logic [V_LOGIC_WIDTH-1:0] ny;
   logic                     legal;
   logic                     accept;
   logic                     apple_rise;

   // Next head from the pending direction.
   always_comb begin
      nx    = seg_x_q[0];
      ny    = seg_y_q[0];
      legal = 1'b1;
      case (pend_q)
`ifdef SNAKE_WRAP_EN
         DIR_UP:    ny = (seg_y_q[0] == '0)   ? YMAX : seg_y_q[0] - 1'b1;
         DIR_RIGHT: nx = (seg_x_q[0] == XMAX) ? '0   : seg_x_q[0] + 1'b1;
         DIR_DOWN:  ny = (seg_y_q[0] == YMAX) ? '0   : seg_y_q[0] + 1'b1;
         default:   nx = (seg_x_q[0] == '0)   ? XMAX : seg_x_q[0] - 1'b1;
`else
         DIR_UP: begin
            legal = (seg_y_q[0] != '0);
            ny    = seg_y_q[0] - 1'b1;
         end
         DIR_RIGHT: begin
            legal = (seg_x_q[0] != XMAX);
            nx    = seg_x_q[0] + 1'b1;
         end
         DIR_DOWN: begin
            legal = (seg_y_q[0] != YMAX);
            ny    = seg_y_q[0] + 1'b1;
         end
         default: begin
            legal = (seg_x_q[0] != '0);
            nx    = seg_x_q[0] - 1'b1;
         end
`endif
      endcase
   end

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      pend_d       = pend_q;
      apple_prev_d = apple_eaten;
      grow_now_d   = grow_now_q;
      len_d        = len_q;
      k_d          = k_q;
      go_d         = go_q;
      seg_x_d      = seg_x_q;
      seg_y_d      = seg_y_q;
      rd_x_d       = seg_x_q[rd_idx];
      rd_y_d       = seg_y_q[rd_idx];
      rd_valid_d   = ({1'b0, rd_idx} < len_q);

      accept     = (state_q == IDLE) && step;
      apple_rise = apple_eaten && !apple_prev_q;

      // Reversal onto the body is discarded outright.
      if (dir_valid && (dir_req != (dir_q ^ 2'd2)))
         pend_d = dir_req;

      // Growth decision is frozen at step acceptance, so an apple edge in the
      // same cycle as the step stays queued for the following step.
      grow_pend_d = apple_rise || (grow_pend_q && !accept);
      if (accept)
         grow_now_d = grow_pend_q;

      case (state_q)
         IDLE: begin
            if (step)
               state_d = MOVE;
         end
         MOVE: begin
            if (legal) begin
               dir_d = pend_q;
               for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x_d[i] = seg_x_q[i-1];
                  seg_y_d[i] = seg_y_q[i-1];
               end
               seg_x_d[0] = nx;
               seg_y_d[0] = ny;
               if (grow_now_q && (len_q < LEN_MAX))
                  len_d = len_q + 1'b1;
               k_d     = IDX_WIDTH'(1);
               state_d = CHECK;
            end else begin
               go_d    = 1'b1;
               state_d = DEAD;
            end
         end
         CHECK: begin
            if ((seg_x_q[k_q] == seg_x_q[0]) && (seg_y_q[k_q] == seg_y_q[0])) begin
               go_d    = 1'b1;
               state_d = DEAD;
            end else if ({1'b0, k_q} == (len_q - 1'b1)) begin
               state_d = IDLE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dir_q        <= DIR_RIGHT;
         pend_q       <= DIR_RIGHT;
         apple_prev_q <= 1'b0;
         grow_pend_q  <= 1'b0;
         grow_now_q   <= 1'b0;
         len_q        <= LEN_INIT;
         k_q          <= '0;
         go_q         <= 1'b0;
         rd_x_q       <= '0;
         rd_y_q       <= '0;
         rd_valid_q   <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            if (i < INIT_LEN) begin
               seg_x_q[i] <= H_LOGIC_WIDTH'(INIT_X - i);
               seg_y_q[i] <= V_LOGIC_WIDTH'(INIT_Y);
            end else begin
               seg_x_q[i] <= '0;
               seg_y_q[i] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         pend_q       <= pend_d;
         apple_prev_q <= apple_prev_d;
         grow_pend_q  <= grow_pend_d;
         grow_now_q   <= grow_now_d;
         len_q        <= len_d;
         k_q          <= k_d;
         go_q         <= go_d;
         rd_x_q       <= rd_x_d;
         rd_y_q       <= rd_y_d;
         rd_valid_q   <= rd_valid_d;
         seg_x_q      <= seg_x_d;
         seg_y_q      <= seg_y_d;
      end
   end

   assign x_snake   = seg_x_q[0];
   assign y_snake   = seg_y_q[0];
   assign length    = 10'(len_q);
   assign rd_x      = rd_x_q;
   assign rd_y      = rd_y_q;
   assign rd_valid  = rd_valid_q;
   assign busy      = (state_q != IDLE);
   assign game_over = go_q;

endmodule

// File: tb/tb_snake_body.sv
module tb_snake_body;

   logic       clk = 1'b0;
   logic       rst;
   logic       step;
   logic       dir_valid;
   logic [1:0] dir_req;
   logic       apple_eaten;
   logic [4:0] rd_idx;
   logic [4:0] x_snake;
   logic [4:0] y_snake;
   logic [9:0] length;
   logic [4:0] rd_x;
   logic [4:0] rd_y;
   logic       rd_valid;
   logic       busy;
   logic       game_over;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   snake_body dut (
      .clk(clk), .rst(rst), .step(step), .dir_valid(dir_valid),
      .dir_req(dir_req), .apple_eaten(apple_eaten), .rd_idx(rd_idx),
      .x_snake(x_snake), .y_snake(y_snake), .length(length),
      .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .busy(busy),
      .game_over(game_over)
   );

   typedef struct {
      bit         dv;
      logic [1:0] d;
      bit         ap;
      logic [4:0] ri;
      int         ex, ey, el;
      bit         ev;
      int         erx, ery;
      bit         eg;
   } vec_t;

   vec_t v[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (busy && !game_over && n < 60) begin
         tick();
         n++;
      end
      chk("wait_done_timeout", (busy && !game_over) ? 1 : 0, 0);
   endtask

   task automatic do_step(input bit dv, input logic [1:0] d, input bit ap);
      if (dv) begin
         dir_valid = 1'b1; dir_req = d; tick(); dir_valid = 1'b0;
      end
      if (ap) begin
         apple_eaten = 1'b1; tick(); apple_eaten = 1'b0; tick();
      end
      step = 1'b1; tick(); step = 1'b0;
      wait_done();
   endtask

   task automatic do_reset();
      rst = 1'b1; step = 1'b0; dir_valid = 1'b0; dir_req = 2'd0;
      apple_eaten = 1'b0; rd_idx = 5'd0;
      tick(); tick();
      rst = 1'b0;
   endtask

   initial begin
      //            dv d     ap ri     x   y  len v  rx  ry go
      v[0] = '{1'b0, 2'd0, 1'b0, 5'd2, 17, 12, 3, 1'b1, 15, 12, 1'b0};
      v[1] = '{1'b1, 2'd3, 1'b0, 5'd1, 18, 12, 3, 1'b1, 17, 12, 1'b0};
      v[2] = '{1'b0, 2'd0, 1'b0, 5'd2, 19, 12, 3, 1'b1, 17, 12, 1'b0};
      v[3] = '{1'b0, 2'd0, 1'b1, 5'd3, 20, 12, 4, 1'b1, 17, 12, 1'b0};
      v[4] = '{1'b0, 2'd0, 1'b0, 5'd4, 21, 12, 4, 1'b0,  0,  0, 1'b0};
      v[5] = '{1'b1, 2'd2, 1'b1, 5'd1, 21, 13, 5, 1'b1, 21, 12, 1'b0};
      v[6] = '{1'b1, 2'd1, 1'b0, 5'd0, 22, 13, 5, 1'b1, 22, 13, 1'b0};
      v[7] = '{1'b1, 2'd2, 1'b0, 5'd2, 22, 14, 5, 1'b1, 21, 13, 1'b0};
      v[8] = '{1'b1, 2'd3, 1'b0, 5'd1, 21, 14, 5, 1'b1, 22, 14, 1'b0};
      v[9] = '{1'b1, 2'd0, 1'b0, 5'd4, 21, 13, 5, 1'b1, 21, 13, 1'b1};

      // Reset values, sampled while reset is still asserted.
      rst = 1'b1; step = 1'b0; dir_valid = 1'b0; dir_req = 2'd0;
      apple_eaten = 1'b0; rd_idx = 5'd0;
      tick(); tick();
      chk("rst_x", x_snake, 16);
      chk("rst_y", y_snake, 12);
      chk("rst_len", length, 3);
      chk("rst_busy", busy, 0);
      chk("rst_go", game_over, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_rdx", rd_x, 0);
      rst = 1'b0;

      // Main table: moves, reversal rejection, growth, self-collision.
      for (int i = 0; i < 10; i++) begin
         do_step(v[i].dv, v[i].d, v[i].ap);
         rd_idx = v[i].ri;
         tick();
         chk($sformatf("v%0d_x", i), x_snake, v[i].ex);
         chk($sformatf("v%0d_y", i), y_snake, v[i].ey);
         chk($sformatf("v%0d_len", i), length, v[i].el);
         chk($sformatf("v%0d_rdv", i), rd_valid, v[i].ev);
         if (v[i].ev) begin
            chk($sformatf("v%0d_rdx", i), rd_x, v[i].erx);
            chk($sformatf("v%0d_rdy", i), rd_y, v[i].ery);
         end
         chk($sformatf("v%0d_go", i), game_over, v[i].eg);
      end

      // DEAD absorbs further steps.
      step = 1'b1; tick(); step = 1'b0; tick(); tick();
      chk("dead_x", x_snake, 21);
      chk("dead_y", y_snake, 13);
      chk("dead_busy", busy, 1);
      chk("dead_go", game_over, 1);

      // Step timing and step dropped during CHECK.
      do_reset();
      step = 1'b1; tick(); step = 1'b0;
      chk("move_busy", busy, 1);
      chk("move_x_old", x_snake, 16);
      tick();
      chk("chk_x_new", x_snake, 17);
      step = 1'b1; tick(); step = 1'b0;
      tick();
      chk("idle_after_scan", busy, 0);
      tick(); tick();
      chk("dropped_step_x", x_snake, 17);
      chk("dropped_step_busy", busy, 0);

      // Reset mid-scan.
      step = 1'b1; tick(); step = 1'b0; tick();
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_x", x_snake, 16);
      chk("midrst_len", length, 3);
      chk("midrst_busy", busy, 0);
      chk("midrst_rdv", rd_valid, 0);

      // Apple edge together with step is applied at the following step.
      do_reset();
      apple_eaten = 1'b1; step = 1'b1; tick(); step = 1'b0;
      wait_done();
      chk("same_cycle_len", length, 3);
      apple_eaten = 1'b0;
      do_step(1'b0, 2'd0, 1'b0);
      chk("next_step_len", length, 4);
      do_step(1'b0, 2'd0, 1'b0);
      chk("len_holds", length, 4);

      // Right edge: 15 steps reach X=31, one more hits the wall or wraps.
      do_reset();
      for (int i = 0; i < 15; i++) do_step(1'b0, 2'd0, 1'b0);
      chk("edge_x", x_snake, 31);
      do_step(1'b0, 2'd0, 1'b0);
`ifdef SNAKE_WRAP_EN
      chk("wrap_x", x_snake, 0);
      chk("wrap_go", game_over, 0);
`else
      chk("wall_x", x_snake, 31);
      chk("wall_go", game_over, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
